ltl_event_collector_c7lw: RTL
=============================

# ltl_event_collector_c7lw

Downstream stage of the cluster-7 load-word runtime monitor. It consumes the ten per-property violation flags (ltl0..ltl9) and detects newly asserted violations. Each such cycle is logged as a timestamped event in a small FIFO that software or the RM debug unit drains over a valid/ready port. It also keeps sticky per-property status, a saturating drop counter and an interrupt line.

## Interface
Parameters:
- NUM_PROP, 10, number of property flags (bit i = ltl<i>c7lw)
- DEPTH, 8, event FIFO entries (power of two, ≥2)
- TS_W, 32, timestamp width
- DROP_W, 8, dropped-event counter width
- IRQ_THRESH, 4, FIFO occupancy that raises irq (1..DEPTH)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- run  in  1  same run qualifier fed to the automata stage
- ltl_hits  in  NUM_PROP  violation flags from the monitor cluster
- prop_en  in  NUM_PROP  per-property enable mask
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_mask  out  NUM_PROP  newly asserted, enabled properties of head event
- evt_ts  out  TS_W  timestamp of head event
- sticky  out  NUM_PROP  accumulated enabled hits since last clear
- clr  in  1  one-cycle pulse: clear sticky, overflow, drop_cnt
- overflow  out  1  sticky: at least one event dropped
- drop_cnt  out  DROP_W  dropped events, saturating
- irq  out  1  interrupt level

## Operation
- Timestamp counter ts: +1 per cycle while run=1, frozen while run=0, wraps 2^TS_W−1 → 0.
- Edge detect: new = ltl_hits & prop_en & ~prev. prev ← run ? (ltl_hits & prop_en) : 0, so a flag still high after run returns re-fires once.
- Push when run=1 and new≠0: entry {new, ts (value in that cycle)}.
- Pop when evt_valid & evt_ready.
- Full and push, no pop: entry dropped; overflow←1; drop_cnt+1, saturating at all-ones.
- Full, push and pop same cycle: both accepted, count unchanged, no drop.
- Empty, push and evt_ready same cycle: no bypass; entry appears next cycle.
- sticky ← clr ? new_hits : sticky | new_hits, with new_hits = run ? ltl_hits & prop_en : 0. A hit on the clr cycle survives the clear.
- clr with a simultaneous drop: overflow=1, drop_cnt=1 afterwards.
- irq = overflow | (count ≥ IRQ_THRESH), registered.
- prop_en changes take effect in the same cycle. Disabled bits never push and never set sticky.

## Timing
- Reset (reset=0, asynchronous): ts=0, prev=0, FIFO empty, evt_valid=0, evt_mask=0, evt_ts=0, sticky=0, overflow=0, drop_cnt=0, irq=0. Reset mid-burst discards all entries.
- Latency: a hit sampled at edge N gives evt_valid=1 with that event at the head after edge N.
- evt_mask/evt_ts come straight from the head register and stay stable while evt_valid=1 and evt_ready=0.
- evt_valid never drops without a pop or reset.
- sticky, overflow and drop_cnt update at the edge after the causing cycle. irq follows one cycle after count or overflow changes.

## Structure
- Shared package rm_monitor_pkg: NUM_PROP default, TS_W default, typedef mon_evt_t {mask, ts}.
- Sub-module mon_evt_fifo: synchronous FIFO of mon_evt_t with show-ahead head, full/empty/count. Parameterised by DEPTH.
- Top contains ts counter, edge detect, sticky/overflow/drop logic and irq.

## Test plan
- Single pulse: run=1, prop_en=all, ltl_hits=0x004 at ts=5 for 3 cycles → exactly one event {mask 0x004, ts 5}; sticky=0x004.
- Multi-bit and mask: prop_en=0x3FE, ltl_hits=0x003 → event mask 0x002; sticky=0x002; bit0 never logged.
- Overflow: DEPTH=8, evt_ready=0, 10 distinct rising hits → 8 entries with ascending ts; overflow=1; drop_cnt=2; irq=1. Push with pop while full → no drop.
- run gating: ltl_hits held 0x010 across run 1→0→1 → two events. ts frozen during run=0 (second ts = first ts + run=1 cycles only).
- Clear race: clr on a cycle with hit 0x080 and sticky=0x0FF → sticky=0x080; overflow=0; drop_cnt=0.
- Async reset with 5 queued entries, asserted mid-cycle → all outputs 0 immediately. First post-reset event has ts counted from 0.

Source files
------------

// File: rtl/rm_monitor_pkg.sv
// Shared types and default widths for the cluster-7 runtime monitor stages.
package rm_monitor_pkg;

  localparam int unsigned NUM_PROP_DEF = 10;
  localparam int unsigned TS_W_DEF     = 32;

  // One logged event: which enabled properties newly fired, and when.
  typedef struct packed {
    logic [NUM_PROP_DEF-1:0] mask;
    logic [TS_W_DEF-1:0]     ts;
  } mon_evt_t;

endpackage

// File: rtl/mon_evt_fifo.sv
// Synchronous show-ahead FIFO of monitor events with full/empty/count.
module mon_evt_fifo
  import rm_monitor_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter type         entry_t = mon_evt_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  entry_t                     din,
  input  logic                       pop,
  output entry_t                     dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push_acc;
  logic            pop_acc;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Accept a push when there is room or when a pop frees the head slot this cycle.
  always_comb begin
    pop_acc  = pop & ~empty;
    push_acc = push & (~full | pop_acc);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/ltl_event_collector_c7lw.sv
// Collects rising LTL violation flags into a timestamped event FIFO with
// sticky status, saturating drop counter and occupancy/overflow interrupt.
module ltl_event_collector_c7lw
  import rm_monitor_pkg::*;
#(
  parameter int unsigned NUM_PROP   = NUM_PROP_DEF,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TS_W       = TS_W_DEF,
  parameter int unsigned DROP_W     = 8,
  parameter int unsigned IRQ_THRESH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [NUM_PROP-1:0] ltl_hits,
  input  logic [NUM_PROP-1:0] prop_en,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [NUM_PROP-1:0] evt_mask,
  output logic [TS_W-1:0]     evt_ts,
  output logic [NUM_PROP-1:0] sticky,
  input  logic                clr,
  output logic                overflow,
  output logic [DROP_W-1:0]   drop_cnt,
  output logic                irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] IRQ_CNT = CW'(IRQ_THRESH);

  typedef struct packed {
    logic [NUM_PROP-1:0] mask;
    logic [TS_W-1:0]     ts;
  } evt_t;

  logic [TS_W-1:0]     ts_q, ts_d;
  logic [NUM_PROP-1:0] prev_q, prev_d;
  logic [NUM_PROP-1:0] sticky_q, sticky_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                irq_q, irq_d;

  logic [NUM_PROP-1:0] en_hits;
  logic [NUM_PROP-1:0] run_hits;
  logic [NUM_PROP-1:0] rise;
  logic                push;
  logic                pop;
  logic                drop;
  evt_t                push_evt;
  evt_t                head_evt;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;

  mon_evt_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (evt_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .din   (push_evt),
    .pop   (pop),
    .dout  (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_mask  = evt_valid ? head_evt.mask : '0;
  assign evt_ts    = evt_valid ? head_evt.ts   : '0;
  assign sticky    = sticky_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign irq       = irq_q;

  // Edge detect, push/pop/drop decisions and next-state for all status registers.
  always_comb begin
    en_hits  = ltl_hits & prop_en;
    run_hits = run ? en_hits : '0;
    rise     = en_hits & ~prev_q;
    push     = run & (|rise);
    pop      = evt_valid & evt_ready;
    drop     = push & fifo_full & ~pop;
    push_evt = '{mask: rise, ts: ts_q};

    ts_d   = run ? ts_q + TS_W'(1) : ts_q;
    // Clearing prev while stopped makes a flag still high on restart re-fire once.
    prev_d = run_hits;

    sticky_d   = clr ? run_hits : (sticky_q | run_hits);
    overflow_d = clr ? drop     : (overflow_q | drop);
    if (clr) begin
      drop_cnt_d = drop ? DROP_W'(1) : '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    irq_d = overflow_q | (fifo_count >= IRQ_CNT);
  end

  // Status registers, all cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q       <= '0;
      prev_q     <= '0;
      sticky_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      sticky_q   <= sticky_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      irq_q      <= irq_d;
    end
  end

endmodule
